debounce_bank: RTL

//   N-channel pushbutton conditioner, parametrised successor to the single-button debouncer.
//   Per channel: 2-FF sync, tick-based debounce, level output, press/release pulses,

---
 rtl/debounce_bank_pkg.sv | 17 +
 rtl/debounce_bank_tick_gen.sv | 32 +++
 rtl/debounce_bank.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/debounce_bank_pkg.sv
// rtl/debounce_bank_pkg.sv - shared types and helpers for the button debounce bank
package debounce_bank_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HELD = 2'd1,
        ST_LONG = 2'd2
    } hold_state_t;

    localparam int TICKS_PER_SEC = 1000;

    // Counter width able to hold max_val; never narrower than one bit.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/debounce_bank_tick_gen.sv
// rtl/debounce_bank_tick_gen.sv - free-running divider producing one shared 1 ms tick
module debounce_bank_tick_gen
    import debounce_bank_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000,
    parameter int DIV    = 1000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    output logic o_tick
);

    localparam int TC = (CLK_HZ / DIV < 1) ? 1 : CLK_HZ / DIV;
    localparam int CW = cnt_width(TC - 1);

    logic [CW-1:0] r_cnt;
    logic          w_tc;

    assign w_tc   = (r_cnt == CW'(TC - 1));
    assign o_tick = w_tc;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (w_tc) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/debounce_bank.sv
// rtl/debounce_bank.sv - N-channel button conditioner: sync, debounce, press/release, long-press, auto-repeat
module debounce_bank
    import debounce_bank_pkg::*;
#(
    parameter int N_CH       = 4,
    parameter int CLK_HZ     = 50_000_000,
    parameter int ACTIVE_LOW = 1,
    parameter int STABLE_MS  = 10,
    parameter int LONG_MS    = 1000,
    parameter int REPEAT_MS  = 200
) (
    input  logic            i_clk_50MHZ,
    input  logic            i_reset,
    input  logic [N_CH-1:0] i_pb,
    output logic [N_CH-1:0] o_level,
    output logic [N_CH-1:0] o_press,
    output logic [N_CH-1:0] o_release,
    output logic [N_CH-1:0] o_long_press,
    output logic [N_CH-1:0] o_step
);

    localparam int   SW       = cnt_width(STABLE_MS);
    localparam int   HW       = cnt_width(LONG_MS);
    localparam int   RW       = cnt_width(REPEAT_MS);
    localparam logic POL      = (ACTIVE_LOW != 0);
    localparam logic RAW_IDLE = POL;

    logic w_tick;

    debounce_bank_tick_gen #(
        .CLK_HZ (CLK_HZ),
        .DIV    (TICKS_PER_SEC)
    ) u_tick_gen (
        .i_clk   (i_clk_50MHZ),
        .i_rst_n (i_reset),
        .o_tick  (w_tick)
    );

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        logic [1:0]    r_sync;
        logic          w_s;
        logic          w_diff;
        logic          w_flip;
        logic          w_level_nxt;
        logic [SW-1:0] r_stab_cnt;
        logic          r_level;
        logic          r_press;
        logic          r_rel;
        hold_state_t   r_state, w_state_nxt;
        logic [HW-1:0] r_hold_cnt, w_hold_nxt;
        logic [RW-1:0] r_rep_cnt, w_rep_nxt;
        logic          w_long;
        logic          w_rep;
        logic          r_long;
        logic          r_step;

        assign w_s    = r_sync[1] ^ POL;
        assign w_diff = (w_s != r_level);
        // Level flips on the first tick after the stability counter has saturated.
        assign w_flip      = w_diff && w_tick && (r_stab_cnt == SW'(STABLE_MS));
        assign w_level_nxt = r_level ^ w_flip;

        always_ff @(posedge i_clk_50MHZ or negedge i_reset) begin
            if (!i_reset) begin
                r_sync     <= {2{RAW_IDLE}};
                r_stab_cnt <= '0;
                r_level    <= 1'b0;
                r_press    <= 1'b0;
                r_rel      <= 1'b0;
            end else begin
                r_sync  <= {r_sync[0], i_pb[g]};
                r_level <= w_level_nxt;
                r_press <= w_flip & ~r_level;
                r_rel   <= w_flip & r_level;
                if (!w_diff || w_flip) begin
                    r_stab_cnt <= '0;
                end else if (w_tick && (r_stab_cnt != SW'(STABLE_MS))) begin
                    r_stab_cnt <= r_stab_cnt + 1'b1;
                end
            end
        end

        // Hold FSM follows the next level so no long/step pulse can share a cycle with release.
        always_comb begin
            w_state_nxt = r_state;
            w_hold_nxt  = r_hold_cnt;
            w_rep_nxt   = r_rep_cnt;
            w_long      = 1'b0;
            w_rep       = 1'b0;
            if (!w_level_nxt) begin
                w_state_nxt = ST_IDLE;
                w_hold_nxt  = '0;
                w_rep_nxt   = '0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        w_state_nxt = ST_HELD;
                        w_hold_nxt  = '0;
                        w_rep_nxt   = '0;
                    end
                    ST_HELD: begin
                        if (w_tick) begin
                            if (r_hold_cnt == HW'(LONG_MS - 1)) begin
                                w_state_nxt = ST_LONG;
                                w_hold_nxt  = '0;
                                w_rep_nxt   = '0;
                                w_long      = 1'b1;
                            end else begin
                                w_hold_nxt = r_hold_cnt + 1'b1;
                            end
                        end
                    end
                    ST_LONG: begin
                        if ((REPEAT_MS > 0) && w_tick) begin
                            if (r_rep_cnt == RW'(REPEAT_MS - 1)) begin
                                w_rep_nxt = '0;
                                w_rep     = 1'b1;
                            end else begin
                                w_rep_nxt = r_rep_cnt + 1'b1;
                            end
                        end
                    end
                    default: begin
                        w_state_nxt = ST_IDLE;
                        w_hold_nxt  = '0;
                        w_rep_nxt   = '0;
                    end
                endcase
            end
        end

        always_ff @(posedge i_clk_50MHZ or negedge i_reset) begin
            if (!i_reset) begin
                r_state    <= ST_IDLE;
                r_hold_cnt <= '0;
                r_rep_cnt  <= '0;
                r_long     <= 1'b0;
                r_step     <= 1'b0;
            end else begin
                r_state    <= w_state_nxt;
                r_hold_cnt <= w_hold_nxt;
                r_rep_cnt  <= w_rep_nxt;
                r_long     <= w_long;
                r_step     <= (w_flip & ~r_level) | w_rep;
            end
        end

        assign o_level[g]      = r_level;
        assign o_press[g]      = r_press;
        assign o_release[g]    = r_rel;
        assign o_long_press[g] = r_long;
        assign o_step[g]       = r_step;
    end

endmodule
